// File: rtl/drive_pkg.sv
// drive_pkg: shared states, widths and saturation limit for the drive current sequencer
package drive_pkg;
  localparam int ACC_W = 30;
  localparam int OUT_W = 12;
  localparam int OUT_LSB = 15;
  localparam logic [OUT_W-1:0] TARGET_MAX = 12'hFFF;
  typedef enum logic [2:0] {IDLE, MUL_INC, MUL_CAD, MUL_SCL, SAT} state_t;
endpackage

// File: rtl/drive_mul_unit.sv
// drive_mul_unit: shared 30x9 multiplier, right operand picked by state (state, a=acc, inc/cad/scl operands -> p truncated product)
module drive_mul_unit
  import drive_pkg::*;
(
  input  state_t           state,
  input  logic [ACC_W-1:0] a,
  input  logic [8:0]       inc,
  input  logic [5:0]       cad,
  input  logic [2:0]       scl,
  output logic [ACC_W-1:0] p
);
  logic [8:0] b;
  always_comb begin
    b = state == MUL_INC ? inc : state == MUL_CAD ? {3'b0, cad} : state == MUL_SCL ? {6'b0, scl} : '0;
    p = a * {{(ACC_W-9){1'b0}}, b};
  end
endmodule

// File: rtl/drive_mult_seq.sv
// drive_mult_seq: start/done sequencer for torque*incline*cadence*scale with saturation (clk, rst, start, not_pedaling, operands -> busy, done, target_curr)
module drive_mult_seq
  import drive_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             not_pedaling,
  input  logic [11:0]      torque_pos,
  input  logic [8:0]       incline_lim,
  input  logic [5:0]       cadence_factor,
  input  logic [2:0]       scale,
  output logic             busy,
  output logic             done,
  output logic [OUT_W-1:0] target_curr
);
  state_t state, nxt;
  logic [ACC_W-1:0] acc, prod;
  logic [8:0] inc_q;
  logic [5:0] cad_q;
  logic [2:0] scl_q;
  drive_mul_unit u_mul (.state(state), .a(acc), .inc(inc_q), .cad(cad_q), .scl(scl_q), .p(prod));
  always_comb begin
    nxt = state == IDLE ? (start ? MUL_INC : IDLE) : state == MUL_INC ? MUL_CAD :
          state == MUL_CAD ? MUL_SCL : state == MUL_SCL ? SAT : IDLE;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else state <= nxt;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc <= '0;
      inc_q <= '0;
      cad_q <= '0;
      scl_q <= '0;
      done <= 1'b0;
      target_curr <= '0;
    end else begin
      done <= state == SAT;
      if (state == IDLE && start) begin
        inc_q <= incline_lim;
        cad_q <= cadence_factor;
        scl_q <= scale;
        acc <= not_pedaling ? '0 : {{(ACC_W-12){1'b0}}, torque_pos};
      end else if (state == MUL_INC || state == MUL_CAD || state == MUL_SCL) acc <= prod;
      if (state == SAT)
        target_curr <= |acc[ACC_W-1:OUT_LSB+OUT_W] ? TARGET_MAX : acc[OUT_LSB +: OUT_W];
    end
  end
  assign busy = state != IDLE;
endmodule

// File: tb/tb_drive_mult_seq.sv
// tb_drive_mult_seq: scoreboard bench for drive_mult_seq, directed vectors with hand-computed results
module tb_drive_mult_seq;
  logic clk = 0, rst = 1, start = 0, not_pedaling = 0;
  logic [11:0] torque_pos = 0;
  logic [8:0] incline_lim = 0;
  logic [5:0] cadence_factor = 0;
  logic [2:0] scale = 0;
  logic busy, done;
  logic [11:0] target_curr;
  typedef struct {logic [11:0] v; int due;} exp_t;
  exp_t q[$];
  int checks = 0, errors = 0, cyc = 0, dones = 0, pushed = 0;
  drive_mult_seq dut (.clk(clk), .rst(rst), .start(start), .not_pedaling(not_pedaling),
    .torque_pos(torque_pos), .incline_lim(incline_lim), .cadence_factor(cadence_factor),
    .scale(scale), .busy(busy), .done(done), .target_curr(target_curr));
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(string n, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", n, act, exp);
    end
  endtask
  always @(negedge clk) begin
    exp_t e;
    if (!rst && done) begin
      dones++;
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL spurious_done actual=1 required=0 at cycle %0d", cyc);
      end else begin
        e = q.pop_front();
        chk("result", {20'b0, target_curr}, {20'b0, e.v});
        chk("latency", cyc, e.due);
      end
    end
  end
  task automatic set_ops(logic [11:0] tp, logic [8:0] inc, logic [5:0] cad, logic [2:0] scl, logic np);
    torque_pos = tp; incline_lim = inc; cadence_factor = cad; scale = scl; not_pedaling = np;
  endtask
  task automatic go(logic [11:0] tp, logic [8:0] inc, logic [5:0] cad, logic [2:0] scl, logic np,
                    logic [11:0] expv, bit now);
    if (!now) @(negedge clk);
    set_ops(tp, inc, cad, scl, np);
    start = 1;
    q.push_back('{expv, cyc + 5});
    pushed++;
    @(negedge clk);
    start = 0;
    set_ops(0, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) begin
      chk("busy_high", {31'b0, busy}, 1);
      @(negedge clk);
    end
    chk("busy_low", {31'b0, busy}, 0);
  endtask
  initial begin
    #2;
    chk("rst_busy", {31'b0, busy}, 0);
    chk("rst_done", {31'b0, done}, 0);
    chk("rst_curr", {20'b0, target_curr}, 0);
    @(negedge clk);
    rst = 0;
    go(12'h100, 256, 40, 3, 0, 12'h0F0, 0);
    go(12'hFFF, 511, 63, 7, 0, 12'hFFF, 0);
    go(12'h001, 1, 33, 1, 0, 12'h000, 0);
    go(12'h100, 256, 40, 3, 0, 12'h0F0, 0);
    go(12'h100, 256, 40, 3, 1, 12'h000, 0);
    go(12'h100, 256, 40, 3, 0, 12'h0F0, 0);
    go(12'h100, 256, 40, 1, 0, 12'h050, 1);
    go(12'h0, 511, 63, 7, 0, 12'h000, 0);
    @(negedge clk);
    set_ops(12'h100, 256, 40, 3, 0);
    start = 1;
    q.push_back('{12'h0F0, cyc + 5});
    pushed++;
    repeat (3) @(negedge clk);
    start = 0;
    @(negedge clk);
    start = 1;
    @(negedge clk);
    start = 0;
    repeat (8) @(negedge clk);
    chk("hold_idle", {31'b0, busy}, 0);
    chk("hold_curr", {20'b0, target_curr}, 12'h0F0);
    set_ops(12'h100, 256, 40, 1, 0);
    start = 1;
    q.push_back('{12'h050, cyc + 5});
    pushed++;
    @(negedge clk);
    start = 0;
    @(negedge clk);
    chk("mid_busy", {31'b0, busy}, 1);
    #2 rst = 1;
    q.delete();
    pushed--;
    #1;
    chk("async_busy", {31'b0, busy}, 0);
    chk("async_done", {31'b0, done}, 0);
    chk("async_curr", {20'b0, target_curr}, 0);
    @(negedge clk);
    rst = 0;
    repeat (8) @(negedge clk);
    chk("post_rst_curr", {20'b0, target_curr}, 0);
    go(12'h100, 256, 40, 3, 0, 12'h0F0, 0);
    repeat (10) @(negedge clk);
    chk("queue_drained", q.size(), 0);
    chk("done_count", dones, pushed);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
  initial begin
    #50000;
    $display("FAIL timeout actual=%0d required<50000", $time);
    $fatal(1);
  end
endmodule
